// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin multi-master/multi-slave bus; `define BUS_TIMEOUT_EN bounds each ownership to MAX_HOLD cycles
module bus_rr_arbiter #(
  parameter int         N_MASTERS  = 2,
  parameter int         N_SLAVES   = 2,
  parameter int         ADDR_W     = 16,
  parameter int         DATA_W     = 32,
  parameter logic [7:0] SLAVE_BASE = 8'h01,
  parameter int         MAX_HOLD   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_wr,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dout,
  output logic [N_MASTERS-1:0]          m_grant,
  output logic [DATA_W-1:0]             m_din,
  output logic                          m_derr,
  output logic [N_SLAVES-1:0]           s_sel,
  output logic                          s_wr,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_din,
  input  logic [N_SLAVES*DATA_W-1:0]    s_dout,
  output logic                          timeout
);
  localparam int OW = $clog2(N_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_n;
  logic [OW-1:0] r_owner, r_last, w_base, w_pick, w_owner_n, w_last_n;
  logic [N_MASTERS-1:0] r_grant, w_grant_n;
  logic [DATA_W-1:0] r_din, w_rdata;
  logic [N_SLAVES-1:0] w_sel;
  logic [7:0] w_upper;
  logic w_found, w_release, w_load, w_to, w_gnt;
  function automatic logic [OW-1:0] wrap(input int v);
    return OW'(v % N_MASTERS);
  endfunction
  always_comb begin
    w_base = r_state == IDLE ? r_last : r_owner;
    w_found = 1'b0;
    w_pick = w_base;
    for (int i = N_MASTERS; i >= 1; i--) begin
      if (m_req[wrap(int'(w_base) + i)]) begin
        w_found = 1'b1;
        w_pick = wrap(int'(w_base) + i);
      end
    end
    w_release = r_state == BUSY && (!m_req[r_owner] || w_to);
    w_load = (r_state == IDLE || w_release) && w_found;
    w_state_n = (r_state == BUSY && !w_release) || w_load ? BUSY : IDLE;
    w_owner_n = w_load ? w_pick : r_owner;
    w_last_n = w_release ? r_owner : r_last;
    w_grant_n = '0;
    if (w_state_n == BUSY) w_grant_n[w_owner_n] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last <= OW'(N_MASTERS - 1);
      r_din <= '0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_owner <= w_owner_n;
      r_last <= w_last_n;
      if (w_gnt && !s_wr) r_din <= w_rdata;
    end
  end
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0] r_cnt;
  logic r_timeout;
  assign w_to = r_state == BUSY && m_req[r_owner] && r_cnt == CW'(MAX_HOLD - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= w_load ? '0 : r_state == BUSY ? r_cnt + 1'b1 : r_cnt;
      r_timeout <= w_to;
    end
  end
  assign timeout = r_timeout;
`else
  assign w_to = 1'b0;
  assign timeout = 1'b0;
`endif
  assign w_gnt = |r_grant;
  assign s_wr = w_gnt & m_wr[r_owner];
  assign s_addr = w_gnt ? m_addr[r_owner*ADDR_W +: ADDR_W] : '0;
  assign s_din = w_gnt ? m_dout[r_owner*DATA_W +: DATA_W] : '0;
  assign w_upper = s_addr[ADDR_W-1 -: 8];
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_dec
    assign w_sel[k] = w_gnt && ({1'b0, w_upper} == {1'b0, SLAVE_BASE} + 9'(k));
  end
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) w_rdata = w_rdata | (w_sel[k] ? s_dout[k*DATA_W +: DATA_W] : '0);
  end
  assign s_sel = w_sel;
  assign m_derr = w_gnt && !(|w_sel);
  assign m_grant = r_grant;
  assign m_din = r_din;
endmodule
